// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates trap/branch/jump redirects, holds one across hazard stalls, then flushes the wrong path.
// Optional trap source is compiled in with `define PC_TRAP_EN.
module pc_redirect_ctrl #(
  parameter int ADDR_SIZE    = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hazardStall,
  input  logic                 jmpValid,
  input  logic [ADDR_SIZE-1:0] jmpTarget,
  input  logic                 brTaken,
  input  logic [ADDR_SIZE-1:0] brTarget,
`ifdef PC_TRAP_EN
  input  logic                 trapValid,
  input  logic [ADDR_SIZE-1:0] trapVector,
`endif
  output logic                 pcStall,
  output logic [1:0]           selWire,
  output logic [ADDR_SIZE-1:0] jumpTarget1,
  output logic [ADDR_SIZE-1:0] jumpTarget2,
  output logic [ADDR_SIZE-1:0] jumpTarget3,
  output logic                 flush,
  output logic                 pendingValid
);

  localparam int            CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [1:0]    SEL_SEQ  = 2'd0;
  localparam logic [1:0]    SEL_JMP  = 2'd1;
  localparam logic [1:0]    SEL_BR   = 2'd2;
  localparam logic [1:0]    SEL_TRAP = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_FLUSH} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [1:0]             r_pend_code, w_pend_code_nxt;
  logic [ADDR_SIZE-1:0]   r_pend_tgt, w_pend_tgt_nxt;
  logic [ADDR_SIZE-1:0]   r_tgt1, r_tgt2;
  logic                   w_trap_valid;
  logic [ADDR_SIZE-1:0]   w_trap_vec;
  logic [1:0]             w_live_code;
  logic [ADDR_SIZE-1:0]   w_live_tgt;
  logic [1:0]             w_sel;
  logic                   w_stall;
  logic                   w_issue;
  logic [ADDR_SIZE-1:0]   w_issue_tgt;

`ifdef PC_TRAP_EN
  logic [ADDR_SIZE-1:0]   r_tgt3;
  assign w_trap_valid = trapValid;
  assign w_trap_vec   = trapVector;
`else
  assign w_trap_valid = 1'b0;
  assign w_trap_vec   = '0;
`endif

  // Jumps and branches seen during FLUSH are wrong-path; only a trap may win there.
  always_comb begin
    w_live_code = SEL_SEQ;
    w_live_tgt  = '0;
    if (w_trap_valid) begin
      w_live_code = SEL_TRAP;
      w_live_tgt  = w_trap_vec;
    end else if (r_state != ST_FLUSH && brTaken) begin
      w_live_code = SEL_BR;
      w_live_tgt  = brTarget;
    end else if (r_state != ST_FLUSH && jmpValid) begin
      w_live_code = SEL_JMP;
      w_live_tgt  = jmpTarget;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pend_code_nxt = r_pend_code;
    w_pend_tgt_nxt  = r_pend_tgt;
    w_sel           = SEL_SEQ;
    w_stall         = hazardStall;
    w_issue         = 1'b0;
    w_issue_tgt     = '0;
    case (r_state)
      ST_IDLE, ST_FLUSH: begin
        if (w_live_code != SEL_SEQ) begin
          if (!hazardStall) begin
            w_sel       = w_live_code;
            w_issue     = 1'b1;
            w_issue_tgt = w_live_tgt;
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_stall         = 1'b1;
            w_pend_code_nxt = w_live_code;
            w_pend_tgt_nxt  = w_live_tgt;
            w_state_nxt     = ST_PENDING;
            w_cnt_nxt       = '0;
          end
        end else if (r_state == ST_FLUSH) begin
          if (r_cnt == '0) w_state_nxt = ST_IDLE;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (!hazardStall) begin
          w_issue = 1'b1;
          if (w_live_code > r_pend_code) begin
            w_sel       = w_live_code;
            w_issue_tgt = w_live_tgt;
          end else begin
            w_sel       = r_pend_code;
            w_issue_tgt = r_pend_tgt;
          end
          w_state_nxt     = ST_FLUSH;
          w_cnt_nxt       = CNT_LOAD;
          w_pend_code_nxt = SEL_SEQ;
          w_pend_tgt_nxt  = '0;
        end else if (w_live_code > r_pend_code) begin
          w_pend_code_nxt = w_live_code;
          w_pend_tgt_nxt  = w_live_tgt;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend_code <= SEL_SEQ;
      r_pend_tgt  <= '0;
      r_tgt1      <= '0;
      r_tgt2      <= '0;
`ifdef PC_TRAP_EN
      r_tgt3      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_code <= w_pend_code_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
      if (w_issue && w_sel == SEL_JMP) r_tgt1 <= w_issue_tgt;
      if (w_issue && w_sel == SEL_BR)  r_tgt2 <= w_issue_tgt;
`ifdef PC_TRAP_EN
      if (w_issue && w_sel == SEL_TRAP) r_tgt3 <= w_issue_tgt;
`endif
    end
  end

  // Outputs are forced quiet while reset is held, regardless of live inputs.
  assign pcStall      = !reset && w_stall;
  assign selWire      = reset ? SEL_SEQ : w_sel;
  assign flush        = !reset && (r_state == ST_FLUSH);
  assign pendingValid = !reset && (r_state == ST_PENDING);
  assign jumpTarget1  = (!reset && w_issue && w_sel == SEL_JMP) ? w_issue_tgt : r_tgt1;
  assign jumpTarget2  = (!reset && w_issue && w_sel == SEL_BR)  ? w_issue_tgt : r_tgt2;
`ifdef PC_TRAP_EN
  assign jumpTarget3  = (!reset && w_issue && w_sel == SEL_TRAP) ? w_issue_tgt : r_tgt3;
`else
  assign jumpTarget3  = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic against a behavioural redirect model.
module tb_pc_redirect_ctrl;
  localparam int AW = 32;
  localparam int FC = 2;
`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          hazardStall, jmpValid, brTaken;
  logic [AW-1:0] jmpTarget, brTarget;
`ifdef PC_TRAP_EN
  logic          trapValid;
  logic [AW-1:0] trapVector;
`endif
  logic          pcStall, flush, pendingValid;
  logic [1:0]    selWire;
  logic [AW-1:0] jumpTarget1, jumpTarget2, jumpTarget3;

  pc_redirect_ctrl #(.ADDR_SIZE(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .hazardStall(hazardStall),
    .jmpValid(jmpValid), .jmpTarget(jmpTarget),
    .brTaken(brTaken), .brTarget(brTarget),
`ifdef PC_TRAP_EN
    .trapValid(trapValid), .trapVector(trapVector),
`endif
    .pcStall(pcStall), .selWire(selWire),
    .jumpTarget1(jumpTarget1), .jumpTarget2(jumpTarget2), .jumpTarget3(jumpTarget3),
    .flush(flush), .pendingValid(pendingValid)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int saw3 = 0;

  // model: at most one held redirect, a count of flush cycles still owed, last target per source
  bit            pend_v;
  int            pend_code;
  logic [AW-1:0] pend_tgt;
  int            flush_left;
  logic [AW-1:0] last_tgt[4];

  logic          a_stall, a_flush, a_pv;
  logic [1:0]    a_sel;
  logic [AW-1:0] a_jt[4];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    pend_v = 1'b0; pend_code = 0; pend_tgt = '0; flush_left = 0;
    for (int n = 0; n < 4; n++) last_tgt[n] = '0;
  endtask

  task automatic capture();
    a_stall = pcStall; a_sel = selWire; a_flush = flush; a_pv = pendingValid;
    a_jt[0] = '0; a_jt[1] = jumpTarget1; a_jt[2] = jumpTarget2; a_jt[3] = jumpTarget3;
  endtask

  // driver + compare: one clock cycle of stimulus, outputs checked mid-cycle against the model
  task automatic step(input bit hz, input bit jv, input logic [AW-1:0] jt,
                      input bit bv, input logic [AW-1:0] bt,
                      input bit tv, input logic [AW-1:0] tvec);
    bit            flushing;
    int            live, e_sel;
    logic [AW-1:0] live_t, e_t;
    @(negedge clk);
    hazardStall = hz; jmpValid = jv; jmpTarget = jt; brTaken = bv; brTarget = bt;
`ifdef PC_TRAP_EN
    trapValid = tv; trapVector = tvec;
`endif
    #1;
    capture();
    flushing = !pend_v && flush_left > 0;
    live = 0; live_t = '0;
    if (TRAP_EN && tv)         begin live = 3; live_t = tvec; end
    else if (!flushing && bv)  begin live = 2; live_t = bt; end
    else if (!flushing && jv)  begin live = 1; live_t = jt; end
    e_sel = 0; e_t = '0;
    chk("flush", {31'd0, a_flush}, {31'd0, flushing});
    chk("pendingValid", {31'd0, a_pv}, {31'd0, pend_v});
    chk("pcStall", {31'd0, a_stall}, {31'd0, hz});
    if (pend_v) begin
      if (!hz) begin
        if (live > pend_code) begin e_sel = live; e_t = live_t; end
        else begin e_sel = pend_code; e_t = pend_tgt; end
        pend_v = 1'b0;
        flush_left = FC;
      end else if (live > pend_code) begin
        pend_code = live; pend_tgt = live_t;
      end
    end else if (live != 0) begin
      if (!hz) begin
        e_sel = live; e_t = live_t; flush_left = FC;
      end else begin
        pend_v = 1'b1; pend_code = live; pend_tgt = live_t; flush_left = 0;
      end
    end else if (flushing) begin
      flush_left--;
    end
    chk("selWire", {30'd0, a_sel}, AW'(e_sel));
    for (int n = 1; n < 4; n++)
      chk($sformatf("jumpTarget%0d", n), a_jt[n], (e_sel == n) ? e_t : last_tgt[n]);
    if (e_sel != 0) last_tgt[e_sel] = e_t;
    if (a_sel == 2'd3) saw3++;
  endtask

  task automatic idle_step(input bit hz);
    step(hz, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    hazardStall = 1'b1; jmpValid = 1'b1; brTaken = 1'b1;
    #1;
    chk("rst_pcStall", {31'd0, pcStall}, 0);
    chk("rst_selWire", {30'd0, selWire}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_pendingValid", {31'd0, pendingValid}, 0);
    chk("rst_jt1", jumpTarget1, 0);
    chk("rst_jt2", jumpTarget2, 0);
    chk("rst_jt3", jumpTarget3, 0);
    model_clear();
    @(negedge clk);
    hazardStall = 1'b0; jmpValid = 1'b0; brTaken = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    hazardStall = 1'b0; jmpValid = 1'b0; brTaken = 1'b0;
    jmpTarget = '0; brTarget = '0;
`ifdef PC_TRAP_EN
    trapValid = 1'b0; trapVector = '0;
`endif
    model_clear();
    do_reset();

    // branch from IDLE: same-cycle redirect, then two flush cycles
    step(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b0, '0);
    chk("s1_sel", {30'd0, a_sel}, 2);
    chk("s1_jt2", a_jt[2], 32'h100);
    chk("s1_stall", {31'd0, a_stall}, 0);
    idle_step(1'b0); chk("s1_flush_a", {31'd0, a_flush}, 1);
    idle_step(1'b0); chk("s1_flush_b", {31'd0, a_flush}, 1);
    idle_step(1'b0); chk("s1_idle", {31'd0, a_flush}, 0);

    // jump held across a three-cycle hazard
    step(1'b1, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0);
    chk("s2_sel_c1", {30'd0, a_sel}, 0);
    chk("s2_stall_c1", {31'd0, a_stall}, 1);
    idle_step(1'b1); chk("s2_pv_c2", {31'd0, a_pv}, 1);
    idle_step(1'b1); chk("s2_stall_c3", {31'd0, a_stall}, 1);
    idle_step(1'b0);
    chk("s2_sel_rel", {30'd0, a_sel}, 1);
    chk("s2_jt1_rel", a_jt[1], 32'h40);
    idle_step(1'b0); idle_step(1'b0);

    // pending jump overtaken by a branch during the stall
    step(1'b1, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 32'h80, 1'b0, '0);
    idle_step(1'b0);
    chk("s3_sel", {30'd0, a_sel}, 2);
    chk("s3_jt2", a_jt[2], 32'h80);
    idle_step(1'b0); chk("s3_no_jump", {30'd0, a_sel}, 0);
    idle_step(1'b0);

    // jump during flush is wrong-path
    step(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b0, '0);
    step(1'b0, 1'b1, 32'h200, 1'b0, '0, 1'b0, '0); chk("s4_sel_a", {30'd0, a_sel}, 0);
    step(1'b0, 1'b1, 32'h200, 1'b0, '0, 1'b0, '0); chk("s4_sel_b", {30'd0, a_sel}, 0);
    idle_step(1'b0); chk("s4_sel_c", {30'd0, a_sel}, 0);

`ifdef PC_TRAP_EN
    step(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1, 32'h4);
    chk("s5_sel", {30'd0, a_sel}, 3);
    chk("s5_jt3", a_jt[3], 32'h4);
    idle_step(1'b0); idle_step(1'b0);
`endif

    // reset while a redirect is pending
    step(1'b1, 1'b1, 32'h40, 1'b0, '0, 1'b0, '0);
    idle_step(1'b1);
    chk("s6_pv_before", {31'd0, a_pv}, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_step(1'b0);
      chk("s6_sel", {30'd0, a_sel}, 0);
      chk("s6_pv", {31'd0, a_pv}, 0);
    end

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, $urandom(),
           $urandom_range(0, 9) < 2, $urandom(), $urandom_range(0, 9) < 1, $urandom());
    end
`ifndef PC_TRAP_EN
    chk("sel_never3", saw3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
